// File: rtl/sha256d_sequencer_if.sv
// Bus between the sha256d sequencer (master) and the SHA-256 compression core (slave).
// The master drives the request (valid, init, chunk, K constant); the core returns
// ready, its current round index and the finished hash words.
interface sha256d_sequencer_if;
    logic        sha_valid;
    logic        sha_ready;
    logic        sha_load_init;
    logic        sha_rst;
    logic [5:0]  sha_round;
    logic [31:0] sha_k;
    logic [31:0] sha_init_0, sha_init_1, sha_init_2, sha_init_3;
    logic [31:0] sha_init_4, sha_init_5, sha_init_6, sha_init_7;
    logic [31:0] sha_chunk_0, sha_chunk_1, sha_chunk_2, sha_chunk_3;
    logic [31:0] sha_chunk_4, sha_chunk_5, sha_chunk_6, sha_chunk_7;
    logic [31:0] sha_chunk_8, sha_chunk_9, sha_chunk_10, sha_chunk_11;
    logic [31:0] sha_chunk_12, sha_chunk_13, sha_chunk_14, sha_chunk_15;
    logic [31:0] sha_hash_0, sha_hash_1, sha_hash_2, sha_hash_3;
    logic [31:0] sha_hash_4, sha_hash_5, sha_hash_6, sha_hash_7;

    modport master (
        output sha_valid, sha_load_init, sha_rst, sha_k,
        output sha_init_0, sha_init_1, sha_init_2, sha_init_3,
        output sha_init_4, sha_init_5, sha_init_6, sha_init_7,
        output sha_chunk_0, sha_chunk_1, sha_chunk_2, sha_chunk_3,
        output sha_chunk_4, sha_chunk_5, sha_chunk_6, sha_chunk_7,
        output sha_chunk_8, sha_chunk_9, sha_chunk_10, sha_chunk_11,
        output sha_chunk_12, sha_chunk_13, sha_chunk_14, sha_chunk_15,
        input  sha_ready, sha_round,
        input  sha_hash_0, sha_hash_1, sha_hash_2, sha_hash_3,
        input  sha_hash_4, sha_hash_5, sha_hash_6, sha_hash_7
    );

    modport slave (
        input  sha_valid, sha_load_init, sha_rst, sha_k,
        input  sha_init_0, sha_init_1, sha_init_2, sha_init_3,
        input  sha_init_4, sha_init_5, sha_init_6, sha_init_7,
        input  sha_chunk_0, sha_chunk_1, sha_chunk_2, sha_chunk_3,
        input  sha_chunk_4, sha_chunk_5, sha_chunk_6, sha_chunk_7,
        input  sha_chunk_8, sha_chunk_9, sha_chunk_10, sha_chunk_11,
        input  sha_chunk_12, sha_chunk_13, sha_chunk_14, sha_chunk_15,
        output sha_ready, sha_round,
        output sha_hash_0, sha_hash_1, sha_hash_2, sha_hash_3,
        output sha_hash_4, sha_hash_5, sha_hash_6, sha_hash_7
    );
endinterface

// File: rtl/sha256d_sequencer.sv
// sha256d nonce-sweep sequencer for a single SHA-256 compression core.
// Per nonce: pass A compresses header block 2 from the midstate, pass B hashes the
// 32-byte pass-A digest from the standard IV, then one CHECK cycle tests the result.
// Optional macro SHA256D_FULL_TARGET_EN: adds target_0..7 and uses a 256-bit
// "hash < target" test; without it a hit is simply sha_hash_7 == 0.
module sha256d_sequencer #(
    parameter bit HALT_ON_FOUND = 1'b1
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] midstate_0, midstate_1, midstate_2, midstate_3,
    input  logic [31:0] midstate_4, midstate_5, midstate_6, midstate_7,
    input  logic [31:0] tail_0, tail_1, tail_2,
    input  logic [31:0] nonce_start,
    input  logic [31:0] nonce_end,
`ifdef SHA256D_FULL_TARGET_EN
    input  logic [31:0] target_0, target_1, target_2, target_3,
    input  logic [31:0] target_4, target_5, target_6, target_7,
`endif
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [31:0] nonce_out,
    output logic [31:0] digest_0, digest_1, digest_2, digest_3,
    output logic [31:0] digest_4, digest_5, digest_6, digest_7,
    sha256d_sequencer_if.master sha
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_A_ISSUE, ST_A_WAIT, ST_B_ISSUE, ST_B_WAIT, ST_CHECK
    } state_e;

    localparam logic [7:0][31:0] SHA_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Job inputs are captured on the accepted start so the controller may change them mid-sweep.
    state_e            state_q, state_d;
    logic [31:0]       nonce_q, nonce_d;
    logic [31:0]       end_q, end_d;
    logic [7:0][31:0]  mid_q, mid_d;
    logic [2:0][31:0]  tail_q, tail_d;
    logic [7:0][31:0]  da_q, da_d;
    logic              first_q, first_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              found_q, found_d;
    logic [31:0]       nonce_out_q, nonce_out_d;
    logic [7:0][31:0]  digest_q, digest_d;
    logic              sha_rst_q, sha_rst_d;

    logic [7:0][31:0]  mid_in;
    logic [2:0][31:0]  tail_in;
    logic [7:0][31:0]  hash_w;
    logic [7:0][31:0]  init_w;
    logic [15:0][31:0] chunk_w;
    logic              pass_b;
    logic              issuing;
    logic              hit;

    assign mid_in  = {midstate_7, midstate_6, midstate_5, midstate_4,
                      midstate_3, midstate_2, midstate_1, midstate_0};
    assign tail_in = {tail_2, tail_1, tail_0};
    assign hash_w  = {sha.sha_hash_7, sha.sha_hash_6, sha.sha_hash_5, sha.sha_hash_4,
                      sha.sha_hash_3, sha.sha_hash_2, sha.sha_hash_1, sha.sha_hash_0};

`ifdef SHA256D_FULL_TARGET_EN
    logic [255:0] hash_le;
    logic [255:0] target_w;

    // Byte-swap each digest word so the compare sees the hash as a little-endian 256-bit number.
    always_comb begin
        hash_le = '0;
        for (int i = 0; i < 8; i++) begin
            hash_le[32*i +: 32] = {hash_w[i][7:0], hash_w[i][15:8], hash_w[i][23:16], hash_w[i][31:24]};
        end
    end

    assign target_w = {target_7, target_6, target_5, target_4, target_3, target_2, target_1, target_0};
    assign hit      = (hash_le < target_w);
`else
    assign hit = (hash_w[7] == 32'h0);
`endif

    // Pass B owns the bus from its issue through CHECK, which still reads the core's hash.
    assign pass_b  = (state_q == ST_B_ISSUE) || (state_q == ST_B_WAIT) || (state_q == ST_CHECK);
    assign issuing = (state_q == ST_A_ISSUE) || (state_q == ST_B_ISSUE);

    // Build the padded message block and init words for the current pass.
    always_comb begin
        chunk_w = '0;
        init_w  = SHA_IV;
        if (pass_b) begin
            chunk_w[7:0] = da_q;
            chunk_w[8]   = 32'h80000000;
            chunk_w[15]  = 32'h00000100;
        end else begin
            init_w      = mid_q;
            chunk_w[0]  = tail_q[0];
            chunk_w[1]  = tail_q[1];
            chunk_w[2]  = tail_q[2];
            chunk_w[3]  = nonce_q;
            chunk_w[4]  = 32'h80000000;
            chunk_w[15] = 32'h00000280;
        end
    end

    // Sweep control: issue / wait for each pass, check the result, advance or finish.
    always_comb begin
        state_d     = state_q;
        nonce_d     = nonce_q;
        end_d       = end_q;
        mid_d       = mid_q;
        tail_d      = tail_q;
        da_d        = da_q;
        first_d     = first_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        found_d     = found_q;
        nonce_out_d = nonce_out_q;
        digest_d    = digest_q;
        sha_rst_d   = 1'b0;
        if (state_q != ST_IDLE && abort) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            sha_rst_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        nonce_d = nonce_start;
                        end_d   = nonce_end;
                        mid_d   = mid_in;
                        tail_d  = tail_in;
                        found_d = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ST_A_ISSUE;
                    end
                end
                ST_A_ISSUE: begin
                    if (sha.sha_ready) begin
                        first_d = 1'b1;
                        state_d = ST_A_WAIT;
                    end
                end
                ST_A_WAIT: begin
                    // The core drops ready one cycle late, so the first wait cycle is skipped.
                    if (first_q) begin
                        first_d = 1'b0;
                    end else if (sha.sha_ready) begin
                        da_d    = hash_w;
                        state_d = ST_B_ISSUE;
                    end
                end
                ST_B_ISSUE: begin
                    if (sha.sha_ready) begin
                        first_d = 1'b1;
                        state_d = ST_B_WAIT;
                    end
                end
                ST_B_WAIT: begin
                    if (first_q) begin
                        first_d = 1'b0;
                    end else if (sha.sha_ready) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (hit) begin
                        found_d = 1'b1;
                    end
                    // Once a hit is held, only a later hit may replace the reported nonce.
                    if (hit || !found_q) begin
                        nonce_out_d = nonce_q;
                        digest_d    = hash_w;
                    end
                    if ((hit && HALT_ON_FOUND) || (nonce_q == end_q)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        nonce_d = nonce_q + 32'd1;
                        state_d = ST_A_ISSUE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            nonce_q     <= '0;
            end_q       <= '0;
            mid_q       <= '0;
            tail_q      <= '0;
            da_q        <= '0;
            first_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            nonce_out_q <= '0;
            digest_q    <= '0;
            sha_rst_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            nonce_q     <= nonce_d;
            end_q       <= end_d;
            mid_q       <= mid_d;
            tail_q      <= tail_d;
            da_q        <= da_d;
            first_q     <= first_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            found_q     <= found_d;
            nonce_out_q <= nonce_out_d;
            digest_q    <= digest_d;
            sha_rst_q   <= sha_rst_d;
        end
    end

    // valid follows ready combinationally so it can never be raised against a busy core.
    assign sha.sha_valid     = issuing && sha.sha_ready && !abort;
    assign sha.sha_load_init = sha.sha_valid;
    assign sha.sha_rst       = sha_rst_q;
    assign sha.sha_k         = K_ROM[sha.sha_round];

    assign sha.sha_init_0 = init_w[0];
    assign sha.sha_init_1 = init_w[1];
    assign sha.sha_init_2 = init_w[2];
    assign sha.sha_init_3 = init_w[3];
    assign sha.sha_init_4 = init_w[4];
    assign sha.sha_init_5 = init_w[5];
    assign sha.sha_init_6 = init_w[6];
    assign sha.sha_init_7 = init_w[7];

    assign sha.sha_chunk_0  = chunk_w[0];
    assign sha.sha_chunk_1  = chunk_w[1];
    assign sha.sha_chunk_2  = chunk_w[2];
    assign sha.sha_chunk_3  = chunk_w[3];
    assign sha.sha_chunk_4  = chunk_w[4];
    assign sha.sha_chunk_5  = chunk_w[5];
    assign sha.sha_chunk_6  = chunk_w[6];
    assign sha.sha_chunk_7  = chunk_w[7];
    assign sha.sha_chunk_8  = chunk_w[8];
    assign sha.sha_chunk_9  = chunk_w[9];
    assign sha.sha_chunk_10 = chunk_w[10];
    assign sha.sha_chunk_11 = chunk_w[11];
    assign sha.sha_chunk_12 = chunk_w[12];
    assign sha.sha_chunk_13 = chunk_w[13];
    assign sha.sha_chunk_14 = chunk_w[14];
    assign sha.sha_chunk_15 = chunk_w[15];

    assign busy      = busy_q;
    assign done      = done_q;
    assign found     = found_q;
    assign nonce_out = nonce_out_q;
    assign digest_0  = digest_q[0];
    assign digest_1  = digest_q[1];
    assign digest_2  = digest_q[2];
    assign digest_3  = digest_q[3];
    assign digest_4  = digest_q[4];
    assign digest_5  = digest_q[5];
    assign digest_6  = digest_q[6];
    assign digest_7  = digest_q[7];

endmodule
